// File: rtl/tetromino_fetch_ctrl.sv
// tetromino_fetch_ctrl: round-robin read controller for the tetromino BRAM.
// Two clients post single-cycle fetch requests. Each request reads one word,
// rotates its 4x4 shape mask clockwise 0..3 quarter turns, and answers with a
// one-cycle response pulse.
//
// state  | meaning
// IDLE   | wait for a pending request, pick a client, range-check its id
// READ   | BRAM chip enable asserted with the granted id on the address
// LOAD   | BRAM data valid, latched into the work register
// ROTATE | one clockwise quarter turn of the shape mask per cycle
// DONE   | response pulse to the granted client, release its pending slot
module tetromino_fetch_ctrl #(
   parameter int DWIDTH    = 32,
   parameter int AWIDTH    = 4,
   parameter int MEM_DEPTH = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_i,
   input  logic              req1_i,
   input  logic [AWIDTH-1:0] id0_i,
   input  logic [AWIDTH-1:0] id1_i,
   input  logic [1:0]        rot0_i,
   input  logic [1:0]        rot1_i,
   input  logic [DWIDTH-1:0] bram_rdata_i,
   output logic              busy0_o,
   output logic              busy1_o,
   output logic              rsp_valid0_o,
   output logic              rsp_valid1_o,
   output logic [DWIDTH-1:0] rsp_data_o,
   output logic              rsp_err_o,
   output logic              bram_ce_o,
   output logic              bram_we_o,
   output logic [AWIDTH-1:0] bram_addr_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_READ   = 3'd1,
      S_LOAD   = 3'd2,
      S_ROTATE = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam logic [31:0] MEM_DEPTH_W = MEM_DEPTH;

   state_t              state_q, state_d;
   logic [1:0]          pend_q, pend_d;
   logic [AWIDTH-1:0]   id0_q, id0_d, id1_q, id1_d;
   logic [1:0]          rot0_q, rot0_d, rot1_q, rot1_d;
   logic                last_q, last_d;
   logic                gnt_q, gnt_d;
   logic                err_q, err_d;
   logic [DWIDTH-1:0]   work_q, work_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [AWIDTH-1:0]   addr_q, addr_d;

   logic                sel;
   logic [AWIDTH-1:0]   sel_id;
   logic [1:0]          gnt_rot;

   // new(r,c) = old(3-c, r)
   function automatic logic [15:0] rot_cw(input logic [15:0] m);
      logic [15:0] res;
      res = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            res[4*r+c] = m[4*(3-c)+r];
         end
      end
      return res;
   endfunction

   // Arbitration: a lone pending client wins; on a tie the one not served last.
   assign sel     = (pend_q == 2'b11) ? ~last_q : pend_q[1];
   assign sel_id  = sel ? id1_q : id0_q;
   assign gnt_rot = gnt_q ? rot1_q : rot0_q;

   // Next-state, request capture and datapath updates.
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      id0_d   = id0_q;
      id1_d   = id1_q;
      rot0_d  = rot0_q;
      rot1_d  = rot1_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      err_d   = err_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;

      // A request is only accepted while that client has nothing outstanding;
      // set and clear of a slot therefore never coincide.
      if (req0_i && !pend_q[0]) begin
         pend_d[0] = 1'b1;
         id0_d     = id0_i;
         rot0_d    = rot0_i;
      end
      if (req1_i && !pend_q[1]) begin
         pend_d[1] = 1'b1;
         id1_d     = id1_i;
         rot1_d    = rot1_i;
      end

      case (state_q)
         S_IDLE: begin
            if (|pend_q) begin
               gnt_d = sel;
               if ({{(32-AWIDTH){1'b0}}, sel_id} >= MEM_DEPTH_W) begin
                  err_d   = 1'b1;
                  work_d  = '0;
                  state_d = S_DONE;
               end else begin
                  err_d   = 1'b0;
                  addr_d  = sel_id;
                  state_d = S_READ;
               end
            end
         end
         S_READ: state_d = S_LOAD;
         S_LOAD: begin
            work_d  = bram_rdata_i;
            cnt_d   = gnt_rot;
            state_d = (gnt_rot == 2'd0) ? S_DONE : S_ROTATE;
         end
         S_ROTATE: begin
            work_d = {work_q[DWIDTH-1:16], rot_cw(work_q[15:0])};
            cnt_d  = cnt_q - 2'd1;
            if (cnt_q == 2'd1) state_d = S_DONE;
         end
         S_DONE: begin
            pend_d[gnt_q] = 1'b0;
            last_d        = gnt_q;
            state_d       = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pend_q  <= 2'b00;
         id0_q   <= '0;
         id1_q   <= '0;
         rot0_q  <= 2'd0;
         rot1_q  <= 2'd0;
         last_q  <= 1'b1;
         gnt_q   <= 1'b0;
         err_q   <= 1'b0;
         work_q  <= '0;
         cnt_q   <= 2'd0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         id0_q   <= id0_d;
         id1_q   <= id1_d;
         rot0_q  <= rot0_d;
         rot1_q  <= rot1_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         err_q   <= err_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
      end
   end

   assign busy0_o      = pend_q[0];
   assign busy1_o      = pend_q[1];
   assign rsp_valid0_o = (state_q == S_DONE) && !gnt_q;
   assign rsp_valid1_o = (state_q == S_DONE) &&  gnt_q;
   assign rsp_data_o   = (state_q == S_DONE) ? work_q : '0;
   assign rsp_err_o    = (state_q == S_DONE) && err_q;
   assign bram_ce_o    = (state_q == S_READ);
   assign bram_we_o    = 1'b0;
   assign bram_addr_o  = addr_q;

endmodule

// File: tb/tb_tetromino_fetch_ctrl.sv
// Directed bench for tetromino_fetch_ctrl. Cycle 0 is the cycle in which the
// request pulse is high; all other cycle numbers are counted from there.
module tb_tetromino_fetch_ctrl;

   logic        clk;
   logic        rst_n;
   logic        req0, req1;
   logic [3:0]  id0, id1;
   logic [1:0]  rot0, rot1;
   logic [31:0] bram_rdata;
   logic        busy0, busy1, rsp_valid0, rsp_valid1, rsp_err;
   logic [31:0] rsp_data;
   logic        bram_ce, bram_we;
   logic [3:0]  bram_addr;

   logic [31:0] mem [16];

   int checks = 0;
   int errors = 0;

   // per-observation results
   int          vcyc [2];
   int          vcnt [2];
   logic [31:0] vdata [2];
   logic        verr [2];
   logic        busy_at [2][32];
   int          ce_cnt, ce_cyc, we_cnt;
   logic [3:0]  ce_addr;

   typedef struct {
      int          client;
      logic [3:0]  id;
      logic [1:0]  rot;
      logic [31:0] exp_data;
      logic        exp_err;
      int          exp_cyc;
   } vec_t;

   vec_t vecs [11];

   tetromino_fetch_ctrl #(.DWIDTH(32), .AWIDTH(4), .MEM_DEPTH(10)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req0_i       (req0),
      .req1_i       (req1),
      .id0_i        (id0),
      .id1_i        (id1),
      .rot0_i       (rot0),
      .rot1_i       (rot1),
      .bram_rdata_i (bram_rdata),
      .busy0_o      (busy0),
      .busy1_o      (busy1),
      .rsp_valid0_o (rsp_valid0),
      .rsp_valid1_o (rsp_valid1),
      .rsp_data_o   (rsp_data),
      .rsp_err_o    (rsp_err),
      .bram_ce_o    (bram_ce),
      .bram_we_o    (bram_we),
      .bram_addr_o  (bram_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read BRAM model: data appears the cycle after chip enable.
   always @(posedge clk) begin
      if (bram_ce) bram_rdata <= mem[bram_addr];
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Sample n cycles starting at cycle number 'start'; leaves the bench at the
   // beginning of the following cycle.
   task automatic observe(input int n, input int start);
      for (int k = 0; k < 2; k++) begin
         vcyc[k] = -1; vcnt[k] = 0; vdata[k] = '0; verr[k] = 1'b0;
         for (int j = 0; j < 32; j++) busy_at[k][j] = 1'bx;
      end
      ce_cnt = 0; ce_cyc = -1; we_cnt = 0; ce_addr = '0;
      for (int c = start; c < start + n; c++) begin
         @(negedge clk);
         busy_at[0][c] = busy0;
         busy_at[1][c] = busy1;
         if (bram_we) we_cnt++;
         if (bram_ce) begin
            ce_cnt++;
            ce_cyc  = c;
            ce_addr = bram_addr;
         end
         if (rsp_valid0) begin
            vcnt[0]++;
            if (vcyc[0] < 0) begin vcyc[0] = c; vdata[0] = rsp_data; verr[0] = rsp_err; end
         end
         if (rsp_valid1) begin
            vcnt[1]++;
            if (vcyc[1] < 0) begin vcyc[1] = c; vdata[1] = rsp_data; verr[1] = rsp_err; end
         end
         next_cycle();
      end
   endtask

   task automatic drive_req(input int client, input logic [3:0] id, input logic [1:0] rot);
      if (client == 0) begin req0 = 1'b1; id0 = id; rot0 = rot; end
      else             begin req1 = 1'b1; id1 = id; rot1 = rot; end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
   endtask

   task automatic run_vec(input vec_t v);
      int o;
      o = 1 - v.client;
      drive_req(v.client, v.id, v.rot);
      next_cycle();
      req0 = 1'b0; req1 = 1'b0;
      observe(14, 1);
      chk("busy_set",    busy_at[v.client][1], 1);
      chk("valid_cycle", vcyc[v.client], v.exp_cyc);
      chk("valid_count", vcnt[v.client], 1);
      chk("other_valid", vcnt[o], 0);
      chk("rsp_data",    vdata[v.client], v.exp_data);
      chk("rsp_err",     verr[v.client], v.exp_err);
      chk("busy_at_done", busy_at[v.client][v.exp_cyc], 1);
      chk("busy_clear",  busy_at[v.client][v.exp_cyc+1], 0);
      chk("bram_we",     we_cnt, 0);
      chk("ce_count",    ce_cnt, v.exp_err ? 0 : 1);
      if (!v.exp_err) begin
         chk("ce_cycle", ce_cyc, 2);
         chk("ce_addr",  ce_addr, v.id);
      end
   endtask

   // Tie: both clients request in cycle 0 (client 0 id 1, client 1 id 2, rot 0).
   task automatic run_tie(input int first, input int second);
      drive_req(0, 4'd1, 2'd0);
      drive_req(1, 4'd2, 2'd0);
      next_cycle();
      req0 = 1'b0; req1 = 1'b0;
      observe(14, 1);
      // IDLE 1, READ 2, LOAD 3, DONE 4; IDLE 5, READ 6, LOAD 7, DONE 8
      chk("tie_first_cycle",  vcyc[first], 4);
      chk("tie_second_cycle", vcyc[second], 8);
      chk("tie_data0",        vdata[0], 32'hA5420001);
      chk("tie_data1",        vdata[1], 32'h127F0013);
      chk("tie_count0",       vcnt[0], 1);
      chk("tie_count1",       vcnt[1], 1);
      chk("tie_busy_clear",   busy_at[second][9], 0);
   endtask

   initial begin
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      id0 = '0; id1 = '0; rot0 = '0; rot1 = '0;
      bram_rdata = '0;
      for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD0000 | i;
      mem[0] = 32'h0003000F;
      mem[1] = 32'hA5420001;
      mem[2] = 32'h127F0013;
      mem[9] = 32'hFFFFFFFF;

      //           client id     rot   expected data   err   cycle
      vecs[0]  = '{0,    4'd0,  2'd0, 32'h0003000F,  1'b0, 4};
      vecs[1]  = '{0,    4'd0,  2'd1, 32'h00038888,  1'b0, 5};
      vecs[2]  = '{0,    4'd0,  2'd2, 32'h0003F000,  1'b0, 6};
      vecs[3]  = '{0,    4'd0,  2'd3, 32'h00031111,  1'b0, 7};
      vecs[4]  = '{1,    4'd1,  2'd1, 32'hA5420008,  1'b0, 5};
      vecs[5]  = '{1,    4'd1,  2'd2, 32'hA5428000,  1'b0, 6};
      vecs[6]  = '{1,    4'd2,  2'd1, 32'h127F008C,  1'b0, 5};
      vecs[7]  = '{1,    4'd10, 2'd0, 32'h00000000,  1'b1, 2};
      vecs[8]  = '{0,    4'd15, 2'd2, 32'h00000000,  1'b1, 2};
      vecs[9]  = '{0,    4'd9,  2'd3, 32'hFFFFFFFF,  1'b0, 7};
      vecs[10] = '{1,    4'd2,  2'd0, 32'h127F0013,  1'b0, 4};

      #3;
      chk("rst_busy0",  busy0, 0);
      chk("rst_busy1",  busy1, 0);
      chk("rst_valid",  {rsp_valid1, rsp_valid0}, 0);
      chk("rst_data",   rsp_data, 0);
      chk("rst_err",    rsp_err, 0);
      chk("rst_ce_we",  {bram_ce, bram_we}, 0);
      chk("rst_addr",   bram_addr, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();

      for (int i = 0; i < 11; i++) run_vec(vecs[i]);

      // last_grant back to 1 so the first tie goes to client 0
      apply_reset();
      run_tie(0, 1);
      // client 1 was served last; a lone client-0 fetch makes client 0 the
      // last grant, so the next tie goes to client 1
      run_vec(vecs[0]);
      run_tie(1, 0);

      // request while busy is dropped
      drive_req(0, 4'd0, 2'd3);
      next_cycle();
      req0 = 1'b0;
      next_cycle();
      drive_req(0, 4'd1, 2'd0);
      next_cycle();
      req0 = 1'b0;
      observe(14, 3);
      chk("busy_ign_count", vcnt[0], 1);
      chk("busy_ign_cycle", vcyc[0], 7);
      chk("busy_ign_data",  vdata[0], 32'h00031111);
      chk("busy_ign_ce",    ce_cnt, 0);

      // reset during ROTATE (cycles 4..6 for rot 3)
      drive_req(0, 4'd0, 2'd3);
      next_cycle();
      req0 = 1'b0;
      repeat (4) next_cycle();
      rst_n = 1'b0;
      #1;
      chk("midrst_busy0", busy0, 0);
      chk("midrst_valid", {rsp_valid1, rsp_valid0}, 0);
      chk("midrst_data",  rsp_data, 0);
      chk("midrst_err",   rsp_err, 0);
      chk("midrst_addr",  bram_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
      observe(10, 1);
      chk("midrst_no_rsp", vcnt[0] + vcnt[1], 0);
      chk("midrst_no_ce",  ce_cnt, 0);
      chk("midrst_idle",   busy_at[0][5], 0);
      run_vec(vecs[1]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard stop in case the sequence above ever stalls.
   initial begin
      #200000;
      $display("FAIL timeout: got no end expected end of sequence");
      $fatal(1, "timeout");
   end

endmodule
